pipe123_drain: RTL
==================

# pipe123_drain

Output drain buffer for the three-stage add pipeline (add 1, add 2, add 3). The pipeline emits one `{valid, data}` slot per clock and has no backpressure. This block absorbs that stream into a small first-word-fall-through FIFO and presents it downstream with a ready/valid handshake. It raises `almost_full` early enough to throttle the pipeline's source, and it records every word lost to overflow.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Must be a power of two and at least 4.
- `AFULL_SLACK`, 3: free entries still remaining when `almost_full` asserts. Equals the number of words in flight in the upstream pipeline.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream slot valid (pipeline valid output).
- `in_data`  in  8  upstream slot data (pipeline data output).
- `out_valid`  out  1  head word available.
- `out_data`  out  8  head word. Driven to 0 whenever `out_valid`=0.
- `out_ready`  in  1  downstream accepts the head word this cycle.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `almost_full`  out  1  `level` >= DEPTH-AFULL_SLACK.
- `overflow`  out  1  sticky; set when a valid input word is dropped.
- `drop_count`  out  8  dropped words, saturating at 255.
- `clr_overflow`  in  1  synchronous clear of `overflow` and `drop_count`.

## Operation
- Storage is a register array of DEPTH x 8 bits. Write and read pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty: pointers are equal.
  - full: low bits are equal and wrap bits differ.
- pop = `out_valid` & `out_ready`. Reads the entry at the read pointer and advances the read pointer.
- push = `in_valid` & (!full | pop). Writes `in_data` at the write pointer and advances the write pointer.
- Full with a simultaneous pop: the push is accepted and `level` stays at DEPTH.
- Empty: there is no bypass. A word pushed at edge N becomes visible only after edge N.
- Drop = `in_valid` & full & !pop.
  - On a drop, `overflow` is set to 1 and `drop_count` increments, holding at 255 once it saturates.
  - FIFO contents and pointers are unchanged by a drop.
- Clear:
  - `clr_overflow`=1 with no drop in the same cycle: `overflow` becomes 0 and `drop_count` becomes 0.
  - `clr_overflow`=1 together with a drop: the event wins, giving `overflow`=1 and `drop_count`=1.
- `level` = write pointer minus read pointer, modulo 2^($clog2(DEPTH)+1).
- `in_data` is ignored when `in_valid`=0.

## Timing
- Reset values, applied immediately on `rst`=0 regardless of the clock:
  - `out_valid`=0, `out_data`=0, `level`=0, `almost_full`=0, `overflow`=0, `drop_count`=0.
  - Both pointers are 0.
  - Array contents are not reset.
- Reset mid-operation discards all stored words. The first push after reset release lands in entry 0.
- Latency: a word pushed at edge N is presented on `out_valid`/`out_data` in the cycle after edge N, with a minimum residency of 1 cycle.
- `out_valid`, `out_data`, `level` and `almost_full` are decoded from registered state only. They have no combinational path from `in_valid` or `out_ready`.
- Throughput: one push and one pop per cycle, sustained.
- Downstream handshake: once `out_valid` is high, the head word and `out_valid` hold until a pop.

## Structure
- Shared package `pipe123_pkg` holds:
  - `WORD_W` = 8.
  - `slot_t` packed struct `{logic valid; logic [WORD_W-1:0] data;}`, which is also used by the pipeline stages.
  - `PIPE_INFLIGHT` = 3, the default for `AFULL_SLACK`.
- No sub-module. Pointers, storage and the saturating drop counter live inline in `pipe123_drain`.

## Test plan
- Reset: hold `rst`=0 with random inputs. All outputs read 0. Release, then push 0x16; `out_valid`=1 and `out_data`=0x16 one cycle later.
- Ordering: with `out_ready`=0, push 0x16, 0x17, 0x18, so `level` reaches 3. Then raise `out_ready`. Outputs must appear as 0x16, 0x17, 0x18 on consecutive cycles, with `level` going 2, 1, 0.
- Overflow: with `out_ready`=0, push 10 words 0x00..0x09.
  - `almost_full` rises at `level`=5.
  - `level`=8, `overflow`=1, `drop_count`=2.
  - Draining yields exactly 0x00..0x07.
- Full plus simultaneous pop: at `level`=8, hold `in_valid`=1 and `out_ready`=1 for 20 cycles. `level` stays 8, `overflow` stays 0, and output order is preserved.
- Saturation and clear:
  - 300 drops give `drop_count`=255.
  - `clr_overflow` alone gives `overflow`=0, `drop_count`=0.
  - `clr_overflow` together with a drop gives `overflow`=1, `drop_count`=1.
- Reset mid-stream: with `level`=5, pulse `rst` low between clock edges. Outputs go to 0 without waiting for a clock edge. After release, push 0xAA; the next popped word is 0xAA.

Source files
------------

// File: rtl/pipe123_pkg.sv
// Shared types and constants for the three-stage add pipeline and its drain buffer.
// The saturating increment lives here so every block counts events the same way.
package pipe123_pkg;

  localparam int WORD_W        = 8;
  localparam int PIPE_INFLIGHT = 3;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] data;
  } slot_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/pipe123_drain.sv
// Drain buffer: absorbs the pipeline's unthrottled slot stream into a FWFT FIFO,
// presents it with ready/valid, warns early via almost_full and counts dropped words.
module pipe123_drain
  import pipe123_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int AFULL_SLACK = PIPE_INFLIGHT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WORD_W-1:0]        in_data,
  output logic                     out_valid,
  output logic [WORD_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  input  logic                     clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] AFULL_LEVEL = LW'(DEPTH - AFULL_SLACK);

  slot_t             in_slot_s;
  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [LW-1:0]     wr_ptr_r;
  logic [LW-1:0]     rd_ptr_r;
  logic [LW-1:0]     wr_ptr_nxt_s;
  logic [LW-1:0]     rd_ptr_nxt_s;
  logic [LW-1:0]     level_nxt_s;
  logic [WORD_W-1:0] head_nxt_s;
  logic              full_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic              out_valid_r;
  logic [WORD_W-1:0] out_data_r;
  logic [LW-1:0]     level_r;
  logic              almost_full_r;
  logic              overflow_r;
  logic [7:0]        drop_count_r;

  assign in_slot_s = '{valid: in_valid, data: in_data};

  // Handshake decode and next-state pointers; the head word for next cycle is
  // looked up here so every downstream-facing output can be a plain register.
  always_comb begin
    full_s       = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    pop_s        = out_valid_r & out_ready;
    push_s       = in_slot_s.valid & (~full_s | pop_s);
    drop_s       = in_slot_s.valid & full_s & ~pop_s;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = {WORD_W{1'b0}};
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + LW'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + LW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    level_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    // A new head that coincides with the slot being written is the incoming word.
    if (level_nxt_s == LW'(0)) begin
      head_nxt_s = {WORD_W{1'b0}};
    end else if (push_s && (rd_ptr_nxt_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
      head_nxt_s = in_slot_s.data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= in_slot_s.data;
    end
  end

  // Pointers and registered output view of the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r      <= LW'(0);
      rd_ptr_r      <= LW'(0);
      out_valid_r   <= 1'b0;
      out_data_r    <= {WORD_W{1'b0}};
      level_r       <= LW'(0);
      almost_full_r <= 1'b0;
    end else begin
      wr_ptr_r      <= wr_ptr_nxt_s;
      rd_ptr_r      <= rd_ptr_nxt_s;
      out_valid_r   <= (level_nxt_s != LW'(0));
      out_data_r    <= head_nxt_s;
      level_r       <= level_nxt_s;
      almost_full_r <= (level_nxt_s >= AFULL_LEVEL);
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 8'd0;
    end else if (drop_s) begin
      overflow_r   <= 1'b1;
      drop_count_r <= clr_overflow ? 8'd1 : sat_inc8(drop_count_r);
    end else if (clr_overflow) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 8'd0;
    end else begin
      overflow_r   <= overflow_r;
      drop_count_r <= drop_count_r;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign level       = level_r;
  assign almost_full = almost_full_r;
  assign overflow    = overflow_r;
  assign drop_count  = drop_count_r;

endmodule
